mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 16x2 memory between NREQ requesters (default 2: generator and a second agent).
//  Latches one request per transaction, sequences the memory write/read, returns read data and a one-cycle ack.
//  Sits between the requesters and the memory. Drives wr_en, addr and data (through an output-enable) on the memory side.
// PARAMETERS
//  NREQ    2  number of requesters (2..8)
//  AW      4  memory address width
//  DW      2  memory data width
//  RD_LAT  1  memory read latency in cycles (1..15)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-low reset
//  req          in   NREQ     per-requester request, held until ack
//  we           in   NREQ     per-requester write(1)/read(0), valid with req
//  addr_in      in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  wdata_in     in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//  gnt          out  NREQ     one-hot grant, high from ACCESS through ACK
//  ack          out  NREQ     one-hot, one-cycle completion pulse
//  rdata        out  DW       read data, valid while ack of a read is high
//  mem_wr_en    out  1        memory write enable
//  mem_addr     out  AW       memory address
//  mem_data_o   out  DW       write data to memory
//  mem_data_oe  out  1        drive enable for the bidirectional memory data bus
//  mem_data_i   in   DW       read data from memory
// BEHAVIOUR
//  - Reset (rst==0 at an edge): state=IDLE, ptr=0. All outputs are 0: gnt, ack, rdata, mem_*.
//    Any in-flight transaction is dropped with no ack.
//  - FSM: IDLE -> ACCESS -> (write) ACK -> IDLE
//                           (read)  WAIT -> ACK -> IDLE
//  - IDLE: if |req, pick the winner w and latch we[w], addr_in[w] and wdata_in[w]. Go to ACCESS. Otherwise stay.
//    In IDLE, mem_addr=0, mem_wr_en=0 and mem_data_oe=0.
//  - ACCESS (1 cycle): gnt[w]=1, mem_addr=latched addr.
//    Write: mem_wr_en=1, mem_data_oe=1, mem_data_o=latched wdata, then go to ACK.
//    Read: mem_wr_en=0, mem_data_oe=0, load cnt=RD_LAT-1, then go to WAIT.
//  - WAIT: mem_addr is held. Stay while cnt!=0, decrementing cnt each cycle.
//    When cnt==0, capture mem_data_i into rdata and go to ACK.
//  - ACK (1 cycle): ack[w]=1 and gnt[w] stays 1. ptr=(w+1) mod NREQ. Next state is IDLE.
//    rdata holds its value until the next read capture. A write leaves rdata unchanged.
//  - Latency, counting the req-sampled IDLE cycle as 0: write ack at cycle 2, read ack at cycle 2+RD_LAT.
//    Minimum spacing between transactions is 3 (write) or 3+RD_LAT (read) cycles.
//  - Handshake: a requester keeps req/we/addr/wdata stable until it sees ack, and clears req on the ack edge.
//    Inputs are sampled only in IDLE. Dropping req after the IDLE sample does not abort; the transaction completes and acks.
//  - Arbitration (default round-robin): search starts at index ptr and goes up, wrapping. The first set req wins.
//    With all req set continuously, grants rotate 0,1,...,NREQ-1,0.
//  - Boundaries: when req==0, stay in IDLE with no outputs. A new req raised during ACCESS/WAIT/ACK waits for the next IDLE.
//    Address wrap is the requester's concern; no range check is done (AW bits are used as-is).
//  - At most one gnt bit and one ack bit are set in any cycle. gnt and mem_data_oe are never 1 in IDLE.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: fixed priority, the lowest set req index always wins. ptr is not used or updated.
//  Not defined (default): round-robin as above.
// TESTING
//  1. Hold rst=0 for 3 cycles while req=2'b11 -> gnt=0, ack=0, mem_wr_en=0, rdata=0. After release, the first grant goes to requester 0.
//  2. Req0 writes addr=4'hA, wdata=2'b10 -> cycle 1: mem_wr_en=1, mem_addr=A, mem_data_o=2, oe=1. Cycle 2: ack=2'b01.
//  3. Req1 reads addr=4'hA with mem_data_i=2'b10 and RD_LAT=1 -> ack=2'b10 at cycle 3 with rdata=2'b10. mem_wr_en stays 0.
//  4. req=2'b11 held, ack-clear then re-raise -> gnt sequence 01,10,01,10. With MEM_ARB_FIXED_PRIO_EN: 01,01,01.
//  5. rst=0 during WAIT of a read -> next cycle IDLE, ack never pulses, rdata=0. A following request is served normally.
//  6. req0 dropped in ACCESS of its write -> the write still completes and ack[0] pulses at cycle 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port memory between NREQ requesters; latches one request per
// transaction. Define MEM_ARB_FIXED_PRIO_EN for fixed priority (default is round-robin).
module mem_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr_in,
    input  logic [NREQ*DW-1:0] wdata_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               mem_wr_en,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_data_o,
    output logic               mem_data_oe,
    input  logic [DW-1:0]      mem_data_i
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_data_o_q, mem_data_o_d;
    logic              mem_data_oe_q, mem_data_oe_d;
    logic [IdxW-1:0]   winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]   ptr_q, ptr_d;
`endif

    // Winner selection, only consumed while in StIdle.
    always_comb begin
        winner = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) winner = IdxW'(i);
        end
`else
        begin
            logic found;
            int   idx;
            found = 1'b0;
            idx   = 0;
            for (int i = 0; i < int'(NREQ); i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
                if (!found && req[idx]) begin
                    winner = IdxW'(idx);
                    found  = 1'b1;
                end
            end
        end
`endif
    end

    // Next-state logic; output registers are loaded with the values for the state being entered.
    always_comb begin
        int w;
        w             = int'(winner);
        state_d       = state_q;
        win_d         = win_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        gnt_d         = '0;
        ack_d         = '0;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = '0;
        mem_data_o_d  = '0;
        mem_data_oe_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d         = ptr_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    win_d         = winner;
                    we_d          = we[w];
                    addr_d        = addr_in[w*AW +: AW];
                    wdata_d       = wdata_in[w*DW +: DW];
                    state_d       = StAccess;
                    gnt_d[w]      = 1'b1;
                    mem_addr_d    = addr_in[w*AW +: AW];
                    mem_wr_en_d   = we[w];
                    mem_data_oe_d = we[w];
                    mem_data_o_d  = we[w] ? wdata_in[w*DW +: DW] : '0;
                end
            end
            StAccess: begin
                gnt_d      = gnt_q;
                mem_addr_d = addr_q;
                if (we_q) begin
                    ack_d   = gnt_q;
                    state_d = StAck;
                end else begin
                    cnt_d   = CntW'(RD_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                gnt_d      = gnt_q;
                mem_addr_d = addr_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = mem_data_i;
                    ack_d   = gnt_q;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
`ifndef MEM_ARB_FIXED_PRIO_EN
                ptr_d   = (int'(win_q) + 1 >= int'(NREQ)) ? '0 : win_q + 1'b1;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            win_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_o_q  <= '0;
            mem_data_oe_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_o_q  <= mem_data_o_d;
            mem_data_oe_q <= mem_data_oe_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_o  = mem_data_o_q;
    assign mem_data_oe = mem_data_oe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NREQ=2, AW=4, DW=2, RD_LAT=1); expectations are hand-computed.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr_in;
    logic [3:0] wdata_in;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [1:0] rdata;
    logic       mem_wr_en;
    logic [3:0] mem_addr;
    logic [1:0] mem_data_o;
    logic       mem_data_oe;
    logic [1:0] mem_data_i;

    int checks;
    int failures;

    mem_arbiter #(
        .NREQ  (2),
        .AW    (4),
        .DW    (2),
        .RD_LAT(1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_data_o (mem_data_o),
        .mem_data_oe(mem_data_oe),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Step one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        int n;
        checks   = 0;
        failures = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // 1: reset held with both requests pending
        rst = 1'b0; req = 2'b11; we = 2'b00; addr_in = '0; wdata_in = '0; mem_data_i = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("rst_gnt", 32'(gnt), 32'h0);
            check_eq("rst_ack", 32'(ack), 32'h0);
            check_eq("rst_wr_en", 32'(mem_wr_en), 32'h0);
            check_eq("rst_rdata", 32'(rdata), 32'h0);
            check_eq("rst_oe", 32'(mem_data_oe), 32'h0);
        end
        rst = 1'b1;
        cyc();
        check_eq("first_gnt", 32'(gnt), 32'h1);
        cyc();
        cyc();
        check_eq("first_ack", 32'(ack), 32'h1);
        req = 2'b00;
        cyc();

        // 2: requester 0 writes 2'b10 to 4'hA
        req = 2'b01; we = 2'b01; addr_in = 8'h0A; wdata_in = 4'b0010;
        cyc();
        check_eq("wr_en", 32'(mem_wr_en), 32'h1);
        check_eq("wr_addr", 32'(mem_addr), 32'hA);
        check_eq("wr_data", 32'(mem_data_o), 32'h2);
        check_eq("wr_oe", 32'(mem_data_oe), 32'h1);
        check_eq("wr_gnt", 32'(gnt), 32'h1);
        check_eq("wr_ack_early", 32'(ack), 32'h0);
        cyc();
        check_eq("wr_ack", 32'(ack), 32'h1);
        check_eq("wr_gnt_in_ack", 32'(gnt), 32'h1);
        check_eq("wr_en_in_ack", 32'(mem_wr_en), 32'h0);
        req = 2'b00;
        cyc();
        cyc();
        check_eq("idle_gnt", 32'(gnt), 32'h0);
        check_eq("idle_oe", 32'(mem_data_oe), 32'h0);
        check_eq("idle_addr", 32'(mem_addr), 32'h0);

        // 3: requester 1 reads 4'hA, memory returns 2'b10
        req = 2'b10; we = 2'b00; addr_in = 8'hA0; mem_data_i = 2'b10;
        cyc();
        check_eq("rd_gnt", 32'(gnt), 32'h2);
        check_eq("rd_addr", 32'(mem_addr), 32'hA);
        check_eq("rd_wr_en", 32'(mem_wr_en), 32'h0);
        check_eq("rd_oe", 32'(mem_data_oe), 32'h0);
        cyc();
        check_eq("rd_wait_ack", 32'(ack), 32'h0);
        check_eq("rd_wait_addr", 32'(mem_addr), 32'hA);
        cyc();
        check_eq("rd_ack", 32'(ack), 32'h2);
        check_eq("rd_rdata", 32'(rdata), 32'h2);
        check_eq("rd_wr_en_ack", 32'(mem_wr_en), 32'h0);
        req = 2'b00; mem_data_i = 2'b00;
        cyc();

        // 4: both request continuously (writes); acked requester drops, then re-raises
        we = 2'b11; addr_in = 8'h53; wdata_in = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            req = 2'b11;
            n = 0;
            cyc();
            while (ack == 2'b00 && n < 10) begin
                cyc();
                n++;
            end
            check_eq("rot_timeout", 32'(ack != 2'b00), 32'h1);
            check_eq($sformatf("rot_ack%0d", k), 32'(ack), 32'(exp_seq[k]));
            check_eq($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(exp_seq[k]));
            req = req & ~ack;
            cyc();
        end
        req = 2'b00;
        cyc();
        check_eq("rdata_kept_by_writes", 32'(rdata), 32'h2);

        // 5: reset during WAIT of a read, then the same request is served
        req = 2'b01; we = 2'b00; addr_in = 8'h0C; mem_data_i = 2'b11;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check_eq("rstw_ack", 32'(ack), 32'h0);
        check_eq("rstw_rdata", 32'(rdata), 32'h0);
        check_eq("rstw_gnt", 32'(gnt), 32'h0);
        cyc();
        check_eq("rstw_regnt", 32'(gnt), 32'h1);
        cyc();
        check_eq("rstw_noack", 32'(ack), 32'h0);
        cyc();
        check_eq("rstw_ack2", 32'(ack), 32'h1);
        check_eq("rstw_rdata2", 32'(rdata), 32'h3);
        req = 2'b00; mem_data_i = 2'b00;
        cyc();

        // 6: requester 0 drops req during ACCESS of its write
        req = 2'b01; we = 2'b01; addr_in = 8'h03; wdata_in = 4'b0001;
        cyc();
        check_eq("drop_wr_en", 32'(mem_wr_en), 32'h1);
        check_eq("drop_data", 32'(mem_data_o), 32'h1);
        req = 2'b00;
        cyc();
        check_eq("drop_ack", 32'(ack), 32'h1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("quiet_gnt", 32'(gnt), 32'h0);
            check_eq("quiet_ack", 32'(ack), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
